// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and widths for the 5-stage RISC-V pipeline
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [6:0] R_T    = 7'b0110011;
    localparam logic [6:0] I_T    = 7'b0010011;
    localparam logic [6:0] LW_T   = 7'b0000011;
    localparam logic [6:0] JALR_T = 7'b1100111;
    localparam logic [6:0] S_T    = 7'b0100011;
    localparam logic [6:0] B_T    = 7'b1100011;
    localparam logic [6:0] J_T    = 7'b1101111;
    localparam logic [6:0] U_T    = 7'b0110111;
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JALR = 2'b11;
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       lui;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] jump;
        logic [2:0] alu_control;
        logic [2:0] funct3;
    } ctrl_t;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: pipeline register slice with clear (bubble) taking priority over enable
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall hold and bubble insertion
module id_ex_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_d,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            ALUSrcD,
    input  logic            LuiD,
    input  logic            BranchD,
    input  logic [1:0]      ResultSrcD,
    input  logic [1:0]      JumpD,
    input  logic [2:0]      ALUControlD,
    input  logic [2:0]      funct3D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            valid_e,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            LuiE,
    output logic            BranchE,
    output logic [1:0]      ResultSrcE,
    output logic [1:0]      JumpE,
    output logic [2:0]      ALUControlE,
    output logic [2:0]      funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);
    ctrl_t ctrl_d, ctrl_e;
    logic [5*XLEN-1:0] data_e;
    logic [14:0] idx_e;
    logic en, clr;
    // an invalid slot loads as a bubble, but a stall still holds whatever is in E
    assign en  = !stall;
    assign clr = flush || (!stall && !valid_d);
    assign ctrl_d.valid       = valid_d;
    assign ctrl_d.reg_write   = RegWriteD;
    assign ctrl_d.mem_write   = MemWriteD;
    assign ctrl_d.alu_src     = ALUSrcD;
    assign ctrl_d.lui         = LuiD;
    assign ctrl_d.branch      = BranchD;
    assign ctrl_d.result_src  = ResultSrcD;
    assign ctrl_d.jump        = JumpD;
    assign ctrl_d.alu_control = ALUControlD;
    assign ctrl_d.funct3      = funct3D;
    pipe_reg #(.W($bits(ctrl_t))) u_ctrl (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(ctrl_d), .q(ctrl_e)
    );
    pipe_reg #(.W(5*XLEN)) u_data (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d({RD1D, RD2D, ImmExtD, PCD, PCPlus4D}), .q(data_e)
    );
    pipe_reg #(.W(15)) u_idx (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d({Rs1D, Rs2D, RdD}), .q(idx_e)
    );
    assign valid_e     = ctrl_e.valid;
    assign RegWriteE   = ctrl_e.reg_write;
    assign MemWriteE   = ctrl_e.mem_write;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign LuiE        = ctrl_e.lui;
    assign BranchE     = ctrl_e.branch;
    assign ResultSrcE  = ctrl_e.result_src;
    assign JumpE       = ctrl_e.jump;
    assign ALUControlE = ctrl_e.alu_control;
    assign funct3E     = ctrl_e.funct3;
    assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E} = data_e;
    assign {Rs1E, Rs2E, RdE} = idx_e;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed and random checks of id_ex_reg against a cycle model
module tb_id_ex_reg;
    localparam int W = 191;
    logic clk = 0, rst, stall, flush, valid_d;
    logic RegWriteD, MemWriteD, ALUSrcD, LuiD, BranchD;
    logic [1:0] ResultSrcD, JumpD;
    logic [2:0] ALUControlD, funct3D;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic valid_e, RegWriteE, MemWriteE, ALUSrcE, LuiE, BranchE;
    logic [1:0] ResultSrcE, JumpE;
    logic [2:0] ALUControlE, funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic [W-1:0] exp_e;
    logic checking = 0;
    int total = 0, bad = 0;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .LuiD(LuiD),
        .BranchD(BranchD), .ResultSrcD(ResultSrcD), .JumpD(JumpD),
        .ALUControlD(ALUControlD), .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D),
        .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RdD(RdD), .valid_e(valid_e), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .LuiE(LuiE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
        .JumpE(JumpE), .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E),
        .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack_d();
        return {valid_d, RegWriteD, MemWriteD, ALUSrcD, LuiD, BranchD, ResultSrcD, JumpD,
                ALUControlD, funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};
    endfunction

    function automatic logic [W-1:0] pack_e();
        return {valid_e, RegWriteE, MemWriteE, ALUSrcE, LuiE, BranchE, ResultSrcE, JumpE,
                ALUControlE, funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
    endfunction

    // reset, flush and an invalid load all leave an empty slot; stall keeps it; else capture D
    always @(posedge clk)
        exp_e <= (rst || flush || (!stall && !valid_d)) ? '0 : stall ? exp_e : pack_d();

    always @(negedge clk)
        if (checking) begin
            total++;
            if (pack_e() !== exp_e) begin
                bad++;
                $display("FAIL model t=%0t got=%h want=%h", $time, pack_e(), exp_e);
            end
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_d();
        valid_d = 1'($urandom); RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
        ALUSrcD = 1'($urandom); LuiD = 1'($urandom); BranchD = 1'($urandom);
        ResultSrcD = 2'($urandom); JumpD = 2'($urandom);
        ALUControlD = 3'($urandom); funct3D = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
        Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        rand_d();
        valid_d = 1;
        step();
        checking = 1;
        rand_d();
        valid_d = 1; stall = 1;
        step();
        chk("rst_valid", 32'(valid_e), 0);
        chk("rst_regwrite", 32'(RegWriteE), 0);
        chk("rst_rd1", RD1E, 0);
        chk("rst_pc", PCE, 0);
        chk("rst_rd", 32'(RdE), 0);
        rst = 0; stall = 0;
        rand_d();
        valid_d = 1; RegWriteD = 1; MemWriteD = 0; JumpD = 0; BranchD = 0; ResultSrcD = 0;
        ALUControlD = 0; RD1D = 32'h5; RD2D = 32'h7; RdD = 5'd3;
        step();
        chk("load_rd1", RD1E, 32'h5);
        chk("load_rd2", RD2E, 32'h7);
        chk("load_rd", 32'(RdE), 3);
        chk("load_regwrite", 32'(RegWriteE), 1);
        chk("load_valid", 32'(valid_e), 1);
        chk("load_aluctl", 32'(ALUControlE), 0);
        valid_d = 1; ResultSrcD = 2'b01; RdD = 5'd9; MemWriteD = 0; RegWriteD = 1;
        step();
        chk("lw_ressrc", 32'(ResultSrcE), 1);
        chk("lw_rd", 32'(RdE), 9);
        stall = 1; MemWriteD = 1; RegWriteD = 0; ResultSrcD = 0; RdD = 5'd12; RD2D = 32'hcafe0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ressrc", 32'(ResultSrcE), 1);
            chk("stall_rd", 32'(RdE), 9);
            chk("stall_memwrite", 32'(MemWriteE), 0);
        end
        stall = 0;
        step();
        chk("sw_memwrite", 32'(MemWriteE), 1);
        chk("sw_rd", 32'(RdE), 12);
        chk("sw_rd2", RD2E, 32'hcafe0001);
        valid_d = 1; JumpD = 2'b10; RegWriteD = 1; RdD = 5'd1; MemWriteD = 0; flush = 1;
        step();
        chk("flush_jump", 32'(JumpE), 0);
        chk("flush_regwrite", 32'(RegWriteE), 0);
        chk("flush_rd", 32'(RdE), 0);
        chk("flush_valid", 32'(valid_e), 0);
        valid_d = 1; JumpD = 0; RegWriteD = 0; MemWriteD = 1; RdD = 5'd4; stall = 1; flush = 1;
        step();
        chk("stfl_memwrite", 32'(MemWriteE), 0);
        chk("stfl_valid", 32'(valid_e), 0);
        stall = 0; flush = 0; valid_d = 0; RegWriteD = 1; MemWriteD = 0; RdD = 5'd5;
        step();
        chk("inv_regwrite", 32'(RegWriteE), 0);
        chk("inv_rd", 32'(RdE), 0);
        chk("inv_valid", 32'(valid_e), 0);
        rand_d();
        valid_d = 1; RegWriteD = 1; RdD = 5'd17; RD1D = 32'hdeadbeef;
        step();
        chk("next_rd", 32'(RdE), 17);
        chk("next_rd1", RD1E, 32'hdeadbeef);
        chk("next_valid", 32'(valid_e), 1);
        rst = 1;
        rand_d();
        valid_d = 1;
        step();
        chk("midrst_valid", 32'(valid_e), 0);
        chk("midrst_imm", ImmExtE, 0);
        rst = 0;
        for (int i = 0; i < 60; i++) begin
            rand_d();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 0; stall = 0; flush = 0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register of the 5-stage RISC-V pipeline. It captures the control bundle from the main decoder and ALU decoder, the register-file operands, the immediate, PC values and register indices at the end of ID, and presents them to EX one cycle later. Hazard-unit stall and flush inputs hold the stage or insert a bubble. The bubble carries zeroed control and a zero destination register, so no write or false forward can occur.

## Interface
- XLEN, 32, datapath width (operands, PC, immediate)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current E contents (hazard unit, load-use)
- flush  in  1  replace E contents with a bubble (taken branch/jump, load-use)
- valid_d  in  1  ID holds a real instruction
- RegWriteD, MemWriteD, ALUSrcD, LuiD, BranchD  in  1 each  decoder controls; BranchD = (op == B-type)
- ResultSrcD  in  2  00 ALU, 01 memory, 10 PC+4, 11 LUI immediate
- JumpD  in  2  00 none, 10 JAL, 11 JALR
- ALUControlD  in  3  from ALU decoder
- funct3D  in  3  branch condition select
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each
- Rs1D, Rs2D, RdD  in  5 each
- valid_e  out  1
- RegWriteE, MemWriteE, ALUSrcE, LuiE, BranchE  out  1 each
- ResultSrcE, JumpE  out  2 each
- ALUControlE, funct3E  out  3 each
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN each
- Rs1E, Rs2E, RdE  out  5 each

## Operation
- Register update priority on each rising clk edge:
  - **rst:** every output is 0.
  - **flush:** bubble. Every output is 0, including data, indices and valid_e.
  - **stall:** all outputs hold their previous values.
  - **Otherwise (load):** outputs take the D-side values.
- Load with valid_d=0 yields a bubble identical to the flush case. D-side controls are ignored.
- Bubble invariant: valid_e=0 implies RegWriteE=0, MemWriteE=0, JumpE=00, BranchE=0 and RdE=0.
  - The bubble never writes the register file or memory, never redirects the PC, and never matches a forwarding comparison.
- Simultaneous stall and flush: flush wins, and a bubble is inserted.
- Stall over multiple cycles: contents stay bit-identical for the whole stall. Loading resumes on the first cycle with stall=0.
- No arithmetic is done in this stage. All fields pass through at full width with no sign or width change.

## Timing
- Latency is 1 cycle from D inputs to E outputs. Outputs are registered only; there is no combinational path from input to output.
- stall, flush and rst are sampled at the clock edge and take effect on the outputs of the next cycle.
- Reset mid-operation clears the stage in 1 cycle. The first instruction after reset deasserts becomes visible one cycle after it is presented with valid_d=1.
- Throughput is one instruction per cycle when stall=0 and flush=0.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants: R_T, I_T, LW_T, JALR_T, S_T, B_T, J_T, U_T
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4, RES_IMM
  - Jump encodings: JMP_NONE, JMP_JAL, JMP_JALR
  - XLEN
- Sub-module `pipe_reg` is a parameterized-width register with clk, rst, en and clr, where clr has priority over en. It is instantiated once per field group:
  - control group
  - data group
  - index group
- The IF/ID register reuses `pipe_reg`.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with arbitrary D inputs -> all E outputs are 0, valid_e=0.
- **Load:** R-type add with RD1D=0x5, RD2D=0x7, RdD=3, RegWriteD=1, ALUControlD=000 -> next cycle RD1E=0x5, RD2E=0x7, RdE=3, RegWriteE=1, valid_e=1.
- **Stall:** load lw (ResultSrcD=01, RdD=9), then stall=1 for 3 cycles while D changes to sw -> E holds the lw fields (ResultSrcE=01, RdE=9, MemWriteE=0) for all 3 cycles, then takes the sw fields when stall drops.
- **Flush:** JAL (JumpD=10, RegWriteD=1, RdD=1) with flush=1 -> next cycle JumpE=00, RegWriteE=0, RdE=0, valid_e=0.
- **Stall and flush together:** stall=1 and flush=1 with valid S-type input -> bubble: MemWriteE=0, valid_e=0.
- **Invalid input:** valid_d=0 with RegWriteD=1, RdD=5 -> RegWriteE=0, RdE=0, valid_e=0. The next valid instruction passes through unchanged.
